// File: rtl/bus_timer.sv
// Memory-mapped 32-bit interval timer: TH reload, TL up-counter, TCON control/status.
// Counts prescaled clock ticks, reloads TL from TH on overflow and raises a sticky level irq.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irq
);

    localparam int unsigned    PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [29:0]    TH_WORD   = BASE_ADDR[31:2];
    localparam logic [29:0]    TL_WORD   = BASE_ADDR[31:2] + 30'd1;
    localparam logic [29:0]    TCON_WORD = BASE_ADDR[31:2] + 30'd2;

    logic [31:0]   th_q, th_d;
    logic [31:0]   tl_q, tl_d;
    logic          en_q, en_d;
    logic          ie_q, ie_d;
    logic          is_q, is_d;
    logic [PW-1:0] pcnt_q, pcnt_d;

    logic hit_th, hit_tl, hit_tcon;
    logic wr_th, wr_tl, wr_tcon;
    logic tick, ovf, irq_set;
    logic addr_lsb_unused;

    // Byte lanes are not decoded: every access is a full word.
    assign addr_lsb_unused = ^Address[1:0];

    assign hit_th   = (Address[31:2] == TH_WORD);
    assign hit_tl   = (Address[31:2] == TL_WORD);
    assign hit_tcon = (Address[31:2] == TCON_WORD);

    assign wr_th   = MemWrite && hit_th;
    assign wr_tl   = MemWrite && hit_tl;
    assign wr_tcon = MemWrite && hit_tcon;

    // Pre-edge EN governs the tick, so a write clearing EN still lets this edge count.
    assign tick = en_q && (pcnt_q == PCNT_LAST);

    // A bus write to TL swallows the tick, and with it any overflow.
    assign ovf = tick && (tl_q == 32'hFFFF_FFFF) && !wr_tl;

    // Either the old or the newly written IE arms the interrupt, so a clear never hides an overflow.
    assign irq_set = ovf && (ie_q || (wr_tcon && Write_data[1]));

    always_comb begin
        pcnt_d = pcnt_q;
        if (!en_q || (wr_tcon && !Write_data[0])) begin
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PW'(1);
        end
    end

    always_comb begin
        tl_d = tl_q;
        if (wr_tl) begin
            tl_d = Write_data;
        end else if (ovf) begin
            tl_d = th_q;
        end else if (tick) begin
            tl_d = tl_q + 32'd1;
        end
    end

    always_comb begin
        th_d = th_q;
        if (wr_th) begin
            th_d = Write_data;
        end
    end

    always_comb begin
        en_d = en_q;
        ie_d = ie_q;
        is_d = is_q;
        if (wr_tcon) begin
            en_d = Write_data[0];
            ie_d = Write_data[1];
            is_d = Write_data[2];
        end
        if (irq_set) begin
            is_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            is_q   <= 1'b0;
            pcnt_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            is_q   <= is_d;
            pcnt_q <= pcnt_d;
        end
    end

    // Reads return pre-edge register contents; a same-cycle write is not forwarded.
    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (hit_th) begin
                Read_data = th_q;
            end else if (hit_tl) begin
                Read_data = tl_q;
            end else if (hit_tcon) begin
                Read_data = {29'd0, is_q, ie_q, en_q};
            end
        end
    end

    assign irq = is_q;

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: two instances (PRESCALE 1 and 4) share one bus and are checked
// against directed expectations and a cycle-level register model.
`timescale 1ns/1ps
module tb_bus_timer;

    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE;
    localparam logic [31:0] A_TL   = BASE + 32'd4;
    localparam logic [31:0] A_TC   = BASE + 32'd8;
    localparam logic [31:0] A_NONE = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
    logic [31:0] rd1, rd4;
    logic        irq1, irq4;

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u_t1 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(rd1), .irq(irq1)
    );

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) u_t4 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(rd4), .irq(irq4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Register model, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
    logic [31:0] m_th [2];
    logic [31:0] m_tl [2];
    logic        m_en [2];
    logic        m_ie [2];
    logic        m_is [2];
    int          m_ecnt [2];

    // Observed and expected values from the most recent step.
    logic [31:0] o1, o4, e1, e4;
    logic        i1, i4, ei1, ei4;

    task automatic m_reset;
        for (int i = 0; i < 2; i++) begin
            m_th[i] = '0; m_tl[i] = '0; m_en[i] = 1'b0;
            m_ie[i] = 1'b0; m_is[i] = 1'b0; m_ecnt[i] = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input int i, input logic rd, input logic [31:0] a);
        if (!rd) return 32'h0;
        if (a[31:2] == A_TH[31:2]) return m_th[i];
        if (a[31:2] == A_TL[31:2]) return m_tl[i];
        if (a[31:2] == A_TC[31:2]) return {29'd0, m_is[i], m_ie[i], m_en[i]};
        return 32'h0;
    endfunction

    // One clock edge: ticks come every ps-th enabled cycle counted since enabling.
    task automatic m_edge(input logic wr, input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            int   ps;
            logic w_th, w_tl, w_tc, tick, ovf;
            ps   = (i == 0) ? 1 : 4;
            w_th = wr && (a[31:2] == A_TH[31:2]);
            w_tl = wr && (a[31:2] == A_TL[31:2]);
            w_tc = wr && (a[31:2] == A_TC[31:2]);
            tick = m_en[i] && ((m_ecnt[i] % ps) == ps - 1);
            ovf  = tick && (m_tl[i] == 32'hFFFF_FFFF) && !w_tl;
            if (!m_en[i] || (w_tc && !d[0])) m_ecnt[i] = 0;
            else m_ecnt[i] = m_ecnt[i] + 1;
            if (w_tl) m_tl[i] = d;
            else if (ovf) m_tl[i] = m_th[i];
            else if (tick) m_tl[i] = m_tl[i] + 32'd1;
            if (w_th) m_th[i] = d;
            if (ovf && (m_ie[i] || (w_tc && d[1]))) m_is[i] = 1'b1;
            else if (w_tc) m_is[i] = d[2];
            if (w_tc) begin
                m_en[i] = d[0];
                m_ie[i] = d[1];
            end
        end
    endtask

    // Drive one bus cycle, capture combinational outputs mid-cycle, then advance the model.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead = rd; MemWrite = wr; Address = a; Write_data = d;
        #1;
        o1 = rd1; o4 = rd4; i1 = irq1; i4 = irq4;
        e1 = m_read(0, rd, a); e4 = m_read(1, rd, a);
        ei1 = m_is[0]; ei4 = m_is[1];
        @(posedge clk);
        m_edge(wr, a, d);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, a, d);
    endtask

    task automatic bus_rd(input logic [31:0] a);
        step(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        MemRead = 1'b1; MemWrite = 1'b0; Address = A_TL; Write_data = '0;
        #1;
        total++; if (rd1 !== 32'h0 || rd4 !== 32'h0) begin bad++; $display("FAIL por_tl got=%h/%h want=0", rd1, rd4); end
        total++; if (irq1 !== 1'b0 || irq4 !== 1'b0) begin bad++; $display("FAIL por_irq got=%b/%b want=0", irq1, irq4); end
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        m_edge(MemWrite, Address, Write_data);
        bus_wr(A_TH, 32'h9);
        bus_wr(A_TC, 32'h1);
        bus_wr(A_TL, 32'h5);
        @(negedge clk);
        MemRead = 1'b1; MemWrite = 1'b0; Address = A_TL;
        #1;
        total++; if (rd1 !== 32'h5) begin bad++; $display("FAIL pre_reset_tl got=%h want=5", rd1); end
        reset = 1'b1;
        #1;
        total++; if (rd1 !== 32'h0 || rd4 !== 32'h0) begin bad++; $display("FAIL async_tl got=%h/%h want=0", rd1, rd4); end
        total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL async_irq got=%b want=0", irq1); end
        Address = A_TH;
        #0.5;
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL async_th got=%h want=0", rd1); end
        Address = A_TC;
        #0.5;
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL async_tcon got=%h want=0", rd1); end
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        @(posedge clk);
        m_edge(MemWrite, Address, Write_data);
        bus_rd(A_TL);
        bus_rd(A_TL);
        total++; if (o1 !== 32'h0) begin bad++; $display("FAIL reset_no_count got=%h want=0", o1); end
    endtask

    task automatic test_free_count;
        logic [31:0] exp_tl [5];
        logic        exp_irq [5];
        exp_tl  = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus_wr(A_TC, 32'h0);
        bus_wr(A_TH, 32'h0);
        bus_wr(A_TL, 32'hFFFF_FFFD);
        bus_wr(A_TC, 32'h3);
        for (int k = 0; k < 5; k++) begin
            bus_rd(A_TL);
            total++; if (o1 !== exp_tl[k]) begin bad++; $display("FAIL free_tl[%0d] got=%h want=%h", k, o1, exp_tl[k]); end
            total++; if (i1 !== exp_irq[k]) begin bad++; $display("FAIL free_irq[%0d] got=%b want=%b", k, i1, exp_irq[k]); end
        end
        bus_rd(A_TL);
        bus_rd(A_TL);
        total++; if (i1 !== 1'b1) begin bad++; $display("FAIL free_irq_sticky got=%b want=1", i1); end
    endtask

    task automatic test_clear_race;
        bus_wr(A_TC, 32'h0);
        bus_wr(A_TH, 32'h0);
        bus_wr(A_TL, 32'hFFFF_FFFE);
        bus_wr(A_TC, 32'h3);
        step(1'b0, 1'b0, A_NONE, 32'h0);
        bus_wr(A_TC, 32'h3);
        bus_rd(A_TC);
        total++; if (o1 !== 32'h7) begin bad++; $display("FAIL race_tcon got=%h want=7", o1); end
        total++; if (i1 !== 1'b1) begin bad++; $display("FAIL race_irq got=%b want=1", i1); end
        bus_wr(A_TC, 32'h3);
        bus_rd(A_TC);
        total++; if (o1 !== 32'h3) begin bad++; $display("FAIL clear_tcon got=%h want=3", o1); end
        total++; if (i1 !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b want=0", i1); end
        // IE enabled by the very write that lands on the overflow edge.
        bus_wr(A_TC, 32'h0);
        bus_wr(A_TL, 32'hFFFF_FFFE);
        bus_wr(A_TC, 32'h1);
        step(1'b0, 1'b0, A_NONE, 32'h0);
        bus_wr(A_TC, 32'h3);
        bus_rd(A_TC);
        total++; if (o1 !== 32'h7) begin bad++; $display("FAIL race_new_ie got=%h want=7", o1); end
        // IE off: overflow leaves IS alone.
        bus_wr(A_TC, 32'h0);
        bus_wr(A_TL, 32'hFFFF_FFFE);
        bus_wr(A_TC, 32'h1);
        step(1'b0, 1'b0, A_NONE, 32'h0);
        step(1'b0, 1'b0, A_NONE, 32'h0);
        bus_rd(A_TC);
        total++; if (o1 !== 32'h1 || i1 !== 1'b0) begin bad++; $display("FAIL no_ie got=%h irq=%b want=1 irq=0", o1, i1); end
    endtask

    task automatic test_prescale;
        logic [31:0] want;
        bus_wr(A_TC, 32'h0);
        bus_wr(A_TL, 32'h0);
        bus_wr(A_TC, 32'h1);
        for (int k = 0; k < 14; k++) begin
            bus_rd(A_TL);
            want = 32'(k / 4);
            total++; if (o4 !== want) begin bad++; $display("FAIL ps_tl[%0d] got=%h want=%h", k, o4, want); end
        end
        bus_wr(A_TC, 32'h0);
        bus_wr(A_TC, 32'h1);
        for (int k = 0; k < 8; k++) begin
            bus_rd(A_TL);
            want = 32'(3 + k / 4);
            total++; if (o4 !== want) begin bad++; $display("FAIL ps_reen[%0d] got=%h want=%h", k, o4, want); end
        end
    endtask

    task automatic test_write_priority;
        bus_wr(A_TC, 32'h0);
        bus_wr(A_TL, 32'hFFFF_FFFF);
        bus_wr(A_TC, 32'h3);
        bus_wr(A_TL, 32'hA);
        bus_rd(A_TL);
        total++; if (o1 !== 32'hA) begin bad++; $display("FAIL tl_wins got=%h want=a", o1); end
        bus_rd(A_TC);
        total++; if (o1 !== 32'h3 || i1 !== 1'b0) begin bad++; $display("FAIL tl_wins_is got=%h irq=%b want=3 irq=0", o1, i1); end
        bus_wr(A_TC, 32'h0);
        bus_wr(A_TH, 32'h2);
        bus_wr(A_TL, 32'hFFFF_FFFF);
        bus_wr(A_TC, 32'h1);
        bus_wr(A_TH, 32'h7);
        bus_rd(A_TL);
        total++; if (o1 !== 32'h2) begin bad++; $display("FAIL old_th_reload got=%h want=2", o1); end
        bus_rd(A_TH);
        total++; if (o1 !== 32'h7) begin bad++; $display("FAIL new_th got=%h want=7", o1); end
        step(1'b1, 1'b1, A_TH, 32'h55);
        total++; if (o1 !== 32'h7) begin bad++; $display("FAIL rw_pre_edge got=%h want=7", o1); end
        bus_rd(A_TH);
        total++; if (o1 !== 32'h55) begin bad++; $display("FAIL rw_written got=%h want=55", o1); end
    endtask

    task automatic test_decode;
        bus_wr(A_TH, 32'hDEAD_BEEF);
        bus_rd(A_NONE);
        total++; if (o1 !== 32'h0) begin bad++; $display("FAIL rd_hole got=%h want=0", o1); end
        bus_wr(A_NONE, 32'h123);
        bus_rd(A_TH);
        total++; if (o1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hole_th got=%h want=deadbeef", o1); end
        bus_wr(A_TC, 32'hFFFF_FFF8);
        bus_rd(A_TC);
        total++; if (o1 !== 32'h0) begin bad++; $display("FAIL tcon_upper0 got=%h want=0", o1); end
        bus_wr(A_TC, 32'hFFFF_FFFE);
        bus_rd(A_TC);
        total++; if (o1 !== 32'h6) begin bad++; $display("FAIL tcon_upper6 got=%h want=6", o1); end
        step(1'b0, 1'b0, A_TH, 32'h0);
        total++; if (o1 !== 32'h0) begin bad++; $display("FAIL no_memread got=%h want=0", o1); end
        bus_rd(A_TH | 32'h3);
        total++; if (o1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lsb_ignored got=%h want=deadbeef", o1); end
    endtask

    task automatic test_random;
        logic [31:0] a, d;
        logic        rd, wr;
        int          sel;
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 3));
            rd  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 3) == 0);
            case (sel)
                0: begin a = A_TH; d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 9)); end
                1: begin a = A_TL; d = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 8)) : $urandom; end
                2: begin
                    a = A_TC;
                    d = 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                end
                default: begin a = A_NONE; d = $urandom; end
            endcase
            step(rd, wr, a, d);
            total++; if (o1 !== e1) begin bad++; $display("FAIL rnd_rd1[%0d] got=%h want=%h", n, o1, e1); end
            total++; if (o4 !== e4) begin bad++; $display("FAIL rnd_rd4[%0d] got=%h want=%h", n, o4, e4); end
            total++; if (i1 !== ei1) begin bad++; $display("FAIL rnd_irq1[%0d] got=%b want=%b", n, i1, ei1); end
            total++; if (i4 !== ei4) begin bad++; $display("FAIL rnd_irq4[%0d] got=%b want=%b", n, i4, ei4); end
        end
    endtask

    initial begin
        test_reset();
        test_free_count();
        test_clear_race();
        test_prescale();
        test_write_priority();
        test_decode();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
